// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Purpose  : Shared widths and the write-back entry type for the arbiter.
// Revision : 1.0  initial release
// ============================================================================
package wb_pkg;

  localparam int REG_W  = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [REG_W-1:0]  data;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Purpose  : Circular buffer of load results with a separate occupancy count.
// Revision : 1.0  initial release
// ============================================================================
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_entry_t        din,
  input  logic             pop,
  output wb_entry_t        dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Single-port write-back arbiter (ALU vs buffered LSU) with
//            starvation drain and busy scoreboard. Define WB_BYPASS_EN for
//            write-port bypass outputs.
// Revision : 1.0  initial release
// ============================================================================
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [REG_W-1:0]  alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [REG_W-1:0]  lsu_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
`ifdef WB_BYPASS_EN
  input  logic [ADDR_W-1:0] byp_ra1,
  input  logic [ADDR_W-1:0] byp_ra2,
  output logic              byp_hit1,
  output logic              byp_hit2,
  output logic [REG_W-1:0]  byp_data1,
  output logic [REG_W-1:0]  byp_data2,
`endif
  output logic [NREGS-1:0]  busy,
  output logic              we2,
  output logic [ADDR_W-1:0] wa3,
  output logic [REG_W-1:0]  wd3
);

  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  wb_entry_t         head, lsu_entry, sel;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [FCNT_W-1:0] fifo_count;
  logic              force_drain, alu_win, sel_valid;

  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              we2_q, we2_d;
  logic [ADDR_W-1:0] wa3_q;
  logic [REG_W-1:0]  wd3_q;
  logic [NREGS-1:0]  busy_q, busy_d, set_vec, clr_vec;

  assign lsu_entry = '{rd: lsu_rd, data: lsu_data};
  assign lsu_ready = !fifo_full;
  assign fifo_push = lsu_valid && !fifo_full;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (lsu_entry),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    force_drain = !fifo_empty && (starve_q == CNT_W'(STARVE_LIMIT));
    alu_ready   = !force_drain;
    alu_win     = alu_valid && !force_drain;
    fifo_pop    = !fifo_empty && !alu_win;
    sel_valid   = alu_win || fifo_pop;
    sel         = alu_win ? '{rd: alu_rd, data: alu_data} : head;
    we2_d       = sel_valid && (sel.rd != '0);

    if (fifo_count == '0 || fifo_pop) starve_d = '0;
    else                              starve_d = starve_q + CNT_W'(1);

    // Set wins over clear so a re-issue in the retiring cycle stays pending.
    set_vec = '0;
    clr_vec = '0;
    if (issue_valid) set_vec = NREGS'(1) << issue_rd;
    if (we2_d)       clr_vec = NREGS'(1) << sel.rd;
    busy_d    = (busy_q & ~clr_vec) | set_vec;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
      we2_q    <= 1'b0;
      wa3_q    <= '0;
      wd3_q    <= '0;
      busy_q   <= '0;
    end else begin
      starve_q <= starve_d;
      we2_q    <= we2_d;
      busy_q   <= busy_d;
      if (we2_d) begin
        wa3_q <= sel.rd;
        wd3_q <= sel.data;
      end
    end
  end

  assign we2  = we2_q;
  assign wa3  = wa3_q;
  assign wd3  = wd3_q;
  assign busy = busy_q;

`ifdef WB_BYPASS_EN
  assign byp_hit1  = we2_q && (wa3_q == byp_ra1) && (byp_ra1 != '0);
  assign byp_hit2  = we2_q && (wa3_q == byp_ra2) && (byp_ra2 != '0);
  assign byp_data1 = wd3_q;
  assign byp_data2 = wd3_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Purpose  : Directed self-checking bench for wb_arbiter (FIFO_DEPTH=4,
//            STARVE_LIMIT=8); bypass checks compile in with WB_BYPASS_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid = 1'b0, lsu_valid = 1'b0, issue_valid = 1'b0;
  logic        alu_ready, lsu_ready, we2;
  logic [4:0]  alu_rd = '0, lsu_rd = '0, issue_rd = '0, wa3;
  logic [31:0] alu_data = '0, lsu_data = '0, wd3, busy;
`ifdef WB_BYPASS_EN
  logic [4:0]  byp_ra1 = '0, byp_ra2 = '0;
  logic        byp_hit1, byp_hit2;
  logic [31:0] byp_data1, byp_data2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
`ifdef WB_BYPASS_EN
    .byp_ra1     (byp_ra1),
    .byp_ra2     (byp_ra2),
    .byp_hit1    (byp_hit1),
    .byp_hit2    (byp_hit2),
    .byp_data1   (byp_data1),
    .byp_data2   (byp_data2),
`endif
    .busy        (busy),
    .we2         (we2),
    .wa3         (wa3),
    .wd3         (wd3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready_during: got %b want 1", alu_ready); end
    tick();
    checks++; if (we2 !== 1'b0) begin errors++; $display("FAIL reset_we2: got %b want 0", we2); end
    checks++; if (wa3 !== 5'd0) begin errors++; $display("FAIL reset_wa3: got %0d want 0", wa3); end
    checks++; if (wd3 !== 32'h0) begin errors++; $display("FAIL reset_wd3: got %h want 0", wd3); end
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h want 0", busy); end
    checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL reset_lsu_ready: got %b want 1", lsu_ready); end
    rst = 1'b0;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready_after: got %b want 1", alu_ready); end
  endtask

  task automatic test_alu_only();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL alu_ready: got %b want 1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    checks++; if ({we2, wa3, wd3} !== {1'b1, 5'd5, 32'hDEADBEEF})
      begin errors++; $display("FAIL alu_write: got we2=%b wa3=%0d wd3=%h want 1/5/deadbeef", we2, wa3, wd3); end
    tick();
    checks++; if (we2 !== 1'b0) begin errors++; $display("FAIL alu_we2_one_cycle: got %b want 0", we2); end
  endtask

  task automatic test_collision();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h77;
    tick();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    checks++; if ({we2, wa3, wd3} !== {1'b1, 5'd3, 32'h33})
      begin errors++; $display("FAIL collision_first: got we2=%b wa3=%0d wd3=%h want 1/3/33", we2, wa3, wd3); end
    tick();
    checks++; if ({we2, wa3, wd3} !== {1'b1, 5'd7, 32'h77})
      begin errors++; $display("FAIL collision_second: got we2=%b wa3=%0d wd3=%h want 1/7/77", we2, wa3, wd3); end
    tick();
    checks++; if (we2 !== 1'b0) begin errors++; $display("FAIL collision_idle: got %b want 0", we2); end
  endtask

  // Head enters at cycle 0, waits cycles 1..8 (counter 0..7), forced at cycle 9.
  task automatic test_fifo_full();
    for (int c = 0; c < 10; c++) begin
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'(c);
      lsu_valid = (c < 4); lsu_rd = 5'(10 + c); lsu_data = 32'(32'hA000 + c);
      #1;
      checks++; if (alu_ready !== (c != 9)) begin errors++; $display("FAIL full_alu_ready c=%0d: got %b want %b", c, alu_ready, (c != 9)); end
      checks++; if (lsu_ready !== (c < 4)) begin errors++; $display("FAIL full_lsu_ready c=%0d: got %b want %b", c, lsu_ready, (c < 4)); end
      tick();
      if (c < 9) begin
        checks++; if ({we2, wa3, wd3} !== {1'b1, 5'd1, 32'(c)})
          begin errors++; $display("FAIL full_alu_write c=%0d: got we2=%b wa3=%0d wd3=%h want 1/1/%h", c, we2, wa3, wd3, c); end
      end else begin
        checks++; if ({we2, wa3, wd3} !== {1'b1, 5'd10, 32'hA000})
          begin errors++; $display("FAIL full_forced_write: got we2=%b wa3=%0d wd3=%h want 1/10/a000", we2, wa3, wd3); end
      end
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL drain_alu_ready i=%0d: got %b want 1", i, alu_ready); end
      tick();
      checks++; if ({we2, wa3, wd3} !== {1'b1, 5'(11 + i), 32'(32'hA001 + i)})
        begin errors++; $display("FAIL drain_write i=%0d: got we2=%b wa3=%0d wd3=%h want 1/%0d/%h", i, we2, wa3, wd3, 11 + i, 32'hA001 + i); end
    end
    tick();
    checks++; if ({we2, lsu_ready} !== 2'b01) begin errors++; $display("FAIL drain_empty: got we2=%b lsu_ready=%b want 0/1", we2, lsu_ready); end
  endtask

  task automatic test_scoreboard();
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0;
    checks++; if (busy !== 32'h0000_0200) begin errors++; $display("FAIL sb_set: got %h want 00000200", busy); end
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    tick();
    alu_valid = 1'b0;
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL sb_clear: got %h want 0", busy); end
    issue_valid = 1'b1; issue_rd = 5'd9;
    alu_valid = 1'b1; alu_rd = 5'd9;
    tick();
    issue_valid = 1'b0;
    checks++; if (busy !== 32'h0000_0200) begin errors++; $display("FAIL sb_set_wins: got %h want 00000200", busy); end
    tick();
    alu_valid = 1'b0;
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL sb_reclear: got %h want 0", busy); end
    issue_valid = 1'b1; issue_rd = 5'd0;
    tick();
    issue_valid = 1'b0;
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL sb_x0: got %h want 0", busy); end
  endtask

  task automatic test_x0_reset();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h5;
    tick();
    alu_valid = 1'b0;
    checks++; if (we2 !== 1'b0) begin errors++; $display("FAIL x0_alu_we2: got %b want 0", we2); end
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h6;
    tick();
    lsu_valid = 1'b0;
    tick();
    checks++; if ({we2, lsu_ready} !== 2'b01) begin errors++; $display("FAIL x0_lsu: got we2=%b lsu_ready=%b want 0/1", we2, lsu_ready); end
    // Three buffered loads held back by ALU traffic, then reset mid-cycle.
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
    issue_valid = 1'b1; issue_rd = 5'd4;
    for (int i = 0; i < 3; i++) begin
      lsu_valid = 1'b1; lsu_rd = 5'(21 + i); lsu_data = 32'(32'h2100 + i);
      tick();
      issue_valid = 1'b0;
    end
    lsu_valid = 1'b0;
    checks++; if ({we2, busy[4]} !== 2'b11) begin errors++; $display("FAIL pre_reset: got we2=%b busy4=%b want 1/1", we2, busy[4]); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({we2, wa3, wd3, busy} !== '0) begin errors++; $display("FAIL async_reset: got we2=%b wa3=%0d wd3=%h busy=%h want zeros", we2, wa3, wd3, busy); end
    checks++; if ({lsu_ready, alu_ready} !== 2'b11) begin errors++; $display("FAIL async_reset_ready: got lsu=%b alu=%b want 1/1", lsu_ready, alu_ready); end
    alu_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (we2 !== 1'b0) begin errors++; $display("FAIL post_reset_no_write i=%0d: got %b want 0", i, we2); end
    end
    lsu_valid = 1'b1; lsu_rd = 5'd25; lsu_data = 32'h2525;
    tick();
    lsu_valid = 1'b0;
    tick();
    checks++; if ({we2, wa3, wd3} !== {1'b1, 5'd25, 32'h2525})
      begin errors++; $display("FAIL post_reset_fresh: got we2=%b wa3=%0d wd3=%h want 1/25/2525", we2, wa3, wd3); end
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    byp_ra1 = 5'd5; byp_ra2 = 5'd6;
    tick();
    alu_valid = 1'b0;
    checks++; if ({byp_hit1, byp_data1} !== {1'b1, 32'h1234}) begin errors++; $display("FAIL byp_hit1: got %b/%h want 1/1234", byp_hit1, byp_data1); end
    checks++; if (byp_hit2 !== 1'b0) begin errors++; $display("FAIL byp_miss2: got %b want 0", byp_hit2); end
    byp_ra1 = 5'd0; byp_ra2 = 5'd5;
    #1;
    checks++; if (byp_hit1 !== 1'b0) begin errors++; $display("FAIL byp_x0: got %b want 0", byp_hit1); end
    checks++; if ({byp_hit2, byp_data2} !== {1'b1, 32'h1234}) begin errors++; $display("FAIL byp_hit2: got %b/%h want 1/1234", byp_hit2, byp_data2); end
    tick();
    byp_ra2 = 5'd0;
  endtask
`endif

  initial begin
    test_reset();
    test_alu_only();
    test_collision();
    test_fifo_full();
    test_scoreboard();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    test_x0_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, giving LSU result buffer entries (power of two, >=2).
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 8, giving the max cycles the FIFO head may wait before forced drain.
REQ-003 The block SHALL have ports:
  clk  in  1  single clock, rising edge
  rst  in  1  asynchronous, active-high reset
  alu_valid  in  1  ALU result present
  alu_ready  out  1  ALU result accepted this cycle
  alu_rd  in  5  ALU destination register
  alu_data  in  32  ALU result
  lsu_valid  in  1  load result present
  lsu_ready  out  1  FIFO not full
  lsu_rd  in  5  load destination register
  lsu_data  in  32  load data
  issue_valid  in  1  instruction issued with destination
  issue_rd  in  5  issued destination register
  busy  out  32  scoreboard, bit n = register n pending
  we2  out  1  register file write enable
  wa3  out  5  register file write address
  wd3  out  32  register file write data
REQ-004 Clock and reset SHALL be clk and rst; one clock; reset asynchronous, active-high.

Function
REQ-005 we2/wa3/wd3 SHALL be registered; a write selected in cycle N SHALL appear on we2/wa3/wd3 in cycle N+1 for exactly one cycle.
REQ-006 At most one write SHALL be issued per cycle.
REQ-007 Default priority: ALU over FIFO head; alu_ready=1 unless a forced drain is active.
REQ-008 LSU handshake: entry pushed when lsu_valid && lsu_ready; lsu_ready=0 when FIFO holds FIFO_DEPTH entries; lsu_ready SHALL NOT depend on lsu_valid.
REQ-009 FIFO head SHALL pop in any cycle ALU does not win arbitration; push and pop in the same cycle SHALL leave occupancy unchanged, including when full (lsu_ready stays 0 when full, no simultaneous push).
REQ-010 Starvation counter SHALL increment each cycle the FIFO is non-empty and the head is not popped; reset to 0 on pop or when empty.
REQ-011 When counter == STARVE_LIMIT, forced drain: alu_ready=0, head popped that cycle, counter cleared.
REQ-012 Results with rd==0 SHALL be accepted/popped normally but SHALL NOT assert we2.
REQ-013 busy[n] SHALL set the cycle after issue_valid with issue_rd==n (n!=0) and clear the cycle after a write to n is selected.
REQ-014 Simultaneous set and clear of the same bit SHALL leave the bit set.
REQ-015 busy[0] SHALL be constant 0.
REQ-016 FIFO pointers SHALL wrap modulo FIFO_DEPTH with a separate occupancy count.

Reset
REQ-017 On rst: we2=0, wa3=0, wd3=0, busy=0, FIFO empty, lsu_ready=1, counter=0; applies immediately, mid-operation, discarding buffered results.
REQ-018 alu_ready SHALL be 1 during and after reset.

Configuration
REQ-019 Macro WB_BYPASS_EN defined: extra ports byp_ra1/byp_ra2 (in, 5) and byp_hit1/byp_hit2 (out, 1), byp_data1/byp_data2 (out, 32); byp_hitK=1 when we2 && wa3==byp_raK && byp_raK!=0, byp_dataK=wd3, combinational.
REQ-020 Macro undefined: bypass ports and logic SHALL be absent; all other behaviour identical.

Structure
REQ-021 Shared package wb_pkg SHALL hold REG_W=32, ADDR_W=5, NREGS=32 and the wb_entry_t struct {rd, data}.
REQ-022 The LSU buffer SHALL be a sub-module wb_fifo (parameter DEPTH, push/pop/full/empty/count).

Verification
REQ-023 ALU only: alu_valid, rd=5, data=0xDEADBEEF at cycle 0 -> we2=1, wa3=5, wd3=0xDEADBEEF at cycle 1, alu_ready=1.
REQ-024 Collision: ALU rd=3 and LSU rd=7 valid same cycle -> cycle 1 writes r3, cycle 2 writes r7.
REQ-025 FIFO full: 4 LSU pushes under continuous ALU traffic -> lsu_ready=0 after 4th push; forced drain at counter=8 drops alu_ready for 1 cycle, head written next cycle.
REQ-026 Scoreboard: issue rd=9, then ALU write rd=9 -> busy[9] 1 then 0; issue rd=9 same cycle as write rd=9 selected -> busy[9] stays 1.
REQ-027 x0 and reset: ALU rd=0 -> no we2; rst asserted with 3 FIFO entries -> FIFO empty, busy=0, no further writes.
REQ-028 With WB_BYPASS_EN: byp_ra1=5 while we2 writes r5 = 0x1234 -> byp_hit1=1, byp_data1=0x1234; byp_ra1=0 -> byp_hit1=0.
